euler_dot_pipe: RTL and testbench

//  Upstream stage of the Euler pipe, directly feeding the final add/mul/write stage.
//  Per state row i computes data_pipe1 = sum_j A[i][j]*x[j] and data_pipe2 = sum_k B[i][k]*u[k].

---
 rtl/euler_dot_pipe_pkg.sv | 22 ++
 rtl/multiplier_modified_booth.sv | 82 ++++++++
 rtl/euler_dot_pipe.sv | 190 +++++++++++++++++++
 tb/tb_euler_dot_pipe.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/euler_dot_pipe_pkg.sv
// Shared constants and FSM encoding for the Euler dot-product stage.
// Holds the default widths, fixed-point position and controller state set.
package euler_dot_pipe_pkg;

   localparam int ADD_SIZE_D  = 16;
   localparam int DATA_SIZE_D = 16;
   localparam int GUARD_D     = 4;
   localparam int FRAC_D      = 8;
   localparam int ACC_W_D     = DATA_SIZE_D + GUARD_D;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ROW,
      S_FETCH_C,
      S_FETCH_V,
      S_MUL,
      S_WAIT,
      S_EMIT,
      S_DONE
   } state_t;

endpackage

// File: rtl/multiplier_modified_booth.sv
// Iterative radix-4 Booth multiplier with start/done handshake.
// Result is rescaled by FRAC bits and saturated to W bits; o_ovf flags clipping.
module multiplier_modified_booth #(
   parameter int W    = 16,
   parameter int FRAC = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_start,
   input  logic [W-1:0]        i_a,
   input  logic [W-1:0]        i_b,
   output logic                o_done,
   output logic [W-1:0]        o_p,
   output logic                o_ovf
);

   localparam int STEPS = W / 2;
   localparam int CW    = $clog2(STEPS) + 1;
   localparam logic signed [2*W-1:0] P_MAX = (2*W)'((1 << (W-1)) - 1);
   localparam logic signed [2*W-1:0] P_MIN = ~P_MAX;

   logic signed [2*W-1:0] r_mcand;
   logic signed [2*W-1:0] r_prod;
   logic        [W:0]     r_mplier;
   logic        [CW-1:0]  r_cnt;
   logic                  r_run;
   logic                  r_done;
   logic signed [2*W-1:0] w_pp;
   logic signed [2*W-1:0] w_shift;
   logic                  w_over;
   logic                  w_under;

   // Booth digit from the overlapping triplet {b[2k+1], b[2k], b[2k-1]}
   always_comb begin
      w_pp = '0;
      case (r_mplier[2:0])
         3'b001, 3'b010: w_pp = r_mcand;
         3'b011:         w_pp = r_mcand <<< 1;
         3'b100:         w_pp = -(r_mcand <<< 1);
         3'b101, 3'b110: w_pp = -r_mcand;
         default:        w_pp = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mcand  <= '0;
         r_prod   <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
         r_run    <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (i_start) begin
            r_mcand  <= {{W{i_a[W-1]}}, i_a};
            r_mplier <= {i_b, 1'b0};
            r_prod   <= '0;
            r_cnt    <= '0;
            r_run    <= 1'b1;
         end else if (r_run) begin
            r_prod   <= r_prod + w_pp;
            r_mcand  <= r_mcand <<< 2;
            r_mplier <= {{2{r_mplier[W]}}, r_mplier[W:2]};
            r_cnt    <= r_cnt + CW'(1);
            if (r_cnt == CW'(STEPS - 1)) begin
               r_run  <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign w_shift = r_prod >>> FRAC;
   assign w_over  = (w_shift > P_MAX);
   assign w_under = (w_shift < P_MIN);
   assign o_done  = r_done;
   assign o_ovf   = w_over | w_under;
   assign o_p     = w_over  ? P_MAX[W-1:0] :
                    w_under ? P_MIN[W-1:0] : w_shift[W-1:0];

endmodule

// File: rtl/euler_dot_pipe.sv
// Per-row A*x and B*u dot products fetched word-by-word from shared RAM,
// handed to the final Euler stage one row per valid/ready transfer.
module euler_dot_pipe
   import euler_dot_pipe_pkg::*;
#(
   parameter int ADD_SIZE  = ADD_SIZE_D,
   parameter int DATA_SIZE = DATA_SIZE_D,
   parameter int GUARD     = GUARD_D,
   parameter int FRAC      = FRAC_D
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_start,
   input  logic [ADD_SIZE-1:0]  i_n_dim,
   input  logic [ADD_SIZE-1:0]  i_m_dim,
   input  logic [ADD_SIZE-1:0]  i_a_base,
   input  logic [ADD_SIZE-1:0]  i_b_base,
   input  logic [ADD_SIZE-1:0]  i_x_base,
   input  logic [ADD_SIZE-1:0]  i_u_base,
   output logic                 o_mem_rd,
   output logic [ADD_SIZE-1:0]  o_mem_addr,
   input  logic [DATA_SIZE-1:0] i_mem_data,
   output logic [DATA_SIZE-1:0] o_data_pipe1,
   output logic [DATA_SIZE-1:0] o_data_pipe2,
   output logic                 o_out_valid,
   input  logic                 i_out_ready,
   output logic                 o_sat_flag,
   output logic                 o_busy,
   output logic                 o_done
);

   localparam int ACC_W = DATA_SIZE + GUARD;
   localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'((1 << (DATA_SIZE-1)) - 1);
   localparam logic signed [ACC_W-1:0] ACC_MIN = ~ACC_MAX;

   state_t                  r_state;
   logic [ADD_SIZE-1:0]     r_n, r_m, r_x_base, r_u_base;
   logic [ADD_SIZE-1:0]     r_a_ptr, r_b_ptr, r_j, r_row;
   logic                    r_sel_b;
   logic [DATA_SIZE-1:0]    r_coef;
   logic signed [ACC_W-1:0] r_acc_a, r_acc_b;
   logic                    r_mem_rd;
   logic [ADD_SIZE-1:0]     r_mem_addr;
   logic [DATA_SIZE-1:0]    r_p1, r_p2;
   logic                    r_out_valid, r_sat, r_busy, r_done;

   logic                    w_mul_start, w_mul_done, w_mul_ovf;
   logic [DATA_SIZE-1:0]    w_prod;
   logic signed [ACC_W-1:0] w_prod_ext, w_acc_a_sum, w_acc_b_sum, w_fin_a, w_fin_b;
   logic                    w_clip_a, w_clip_b, w_last_term;
   logic [ADD_SIZE-1:0]     w_j_nxt;

   function automatic logic [DATA_SIZE-1:0] f_clip(input logic signed [ACC_W-1:0] v);
      if (v > ACC_MAX) return ACC_MAX[DATA_SIZE-1:0];
      if (v < ACC_MIN) return ACC_MIN[DATA_SIZE-1:0];
      return v[DATA_SIZE-1:0];
   endfunction

   // Vector word arrives straight from RAM during MUL; the multiplier latches it.
   assign w_mul_start = (r_state == S_MUL);

   multiplier_modified_booth #(.W(DATA_SIZE), .FRAC(FRAC)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .i_start (w_mul_start),
      .i_a     (r_coef),
      .i_b     (i_mem_data),
      .o_done  (w_mul_done),
      .o_p     (w_prod),
      .o_ovf   (w_mul_ovf)
   );

   assign w_prod_ext  = $signed({{GUARD{w_prod[DATA_SIZE-1]}}, w_prod});
   assign w_acc_a_sum = r_acc_a + w_prod_ext;
   assign w_acc_b_sum = r_acc_b + w_prod_ext;
   // Final sums including the term being retired this cycle
   assign w_fin_a     = r_sel_b ? r_acc_a : w_acc_a_sum;
   assign w_fin_b     = r_sel_b ? w_acc_b_sum : r_acc_b;
   assign w_clip_a    = (w_fin_a > ACC_MAX) || (w_fin_a < ACC_MIN);
   assign w_clip_b    = (w_fin_b > ACC_MAX) || (w_fin_b < ACC_MIN);
   assign w_j_nxt     = r_j + ADD_SIZE'(1);
   assign w_last_term = (w_j_nxt == (r_sel_b ? r_m : r_n));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_n         <= '0;
         r_m         <= '0;
         r_x_base    <= '0;
         r_u_base    <= '0;
         r_a_ptr     <= '0;
         r_b_ptr     <= '0;
         r_j         <= '0;
         r_row       <= '0;
         r_sel_b     <= 1'b0;
         r_coef      <= '0;
         r_acc_a     <= '0;
         r_acc_b     <= '0;
         r_mem_rd    <= 1'b0;
         r_mem_addr  <= '0;
         r_p1        <= '0;
         r_p2        <= '0;
         r_out_valid <= 1'b0;
         r_sat       <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: if (i_start) begin
               r_n      <= i_n_dim;
               r_m      <= i_m_dim;
               r_x_base <= i_x_base;
               r_u_base <= i_u_base;
               r_a_ptr  <= i_a_base;
               r_b_ptr  <= i_b_base;
               r_row    <= '0;
               r_sat    <= 1'b0;
               r_busy   <= 1'b1;
               r_state  <= (i_n_dim == '0) ? S_DONE : S_ROW;
            end
            S_ROW: begin
               r_acc_a    <= '0;
               r_acc_b    <= '0;
               r_j        <= '0;
               r_sel_b    <= 1'b0;
               r_mem_rd   <= 1'b1;
               r_mem_addr <= r_a_ptr;
               r_state    <= S_FETCH_C;
            end
            S_FETCH_C: begin
               r_mem_addr <= (r_sel_b ? r_u_base : r_x_base) + r_j;
               if (r_sel_b) r_b_ptr <= r_b_ptr + ADD_SIZE'(1);
               else         r_a_ptr <= r_a_ptr + ADD_SIZE'(1);
               r_state <= S_FETCH_V;
            end
            S_FETCH_V: begin
               r_coef   <= i_mem_data;
               r_mem_rd <= 1'b0;
               r_state  <= S_MUL;
            end
            S_MUL: r_state <= S_WAIT;
            S_WAIT: if (w_mul_done) begin
               if (w_mul_ovf) r_sat <= 1'b1;
               if (r_sel_b) r_acc_b <= w_acc_b_sum;
               else         r_acc_a <= w_acc_a_sum;
               if (w_last_term && (r_sel_b || r_m == '0)) begin
                  r_p1        <= f_clip(w_fin_a);
                  r_p2        <= f_clip(w_fin_b);
                  if (w_clip_a || w_clip_b) r_sat <= 1'b1;
                  r_out_valid <= 1'b1;
                  r_state     <= S_EMIT;
               end else begin
                  r_mem_rd <= 1'b1;
                  r_state  <= S_FETCH_C;
                  if (w_last_term) begin
                     r_sel_b    <= 1'b1;
                     r_j        <= '0;
                     r_mem_addr <= r_b_ptr;
                  end else begin
                     r_j        <= w_j_nxt;
                     r_mem_addr <= r_sel_b ? r_b_ptr : r_a_ptr;
                  end
               end
            end
            S_EMIT: if (i_out_ready) begin
               r_out_valid <= 1'b0;
               r_row       <= r_row + ADD_SIZE'(1);
               r_state     <= ((r_row + ADD_SIZE'(1)) == r_n) ? S_DONE : S_ROW;
            end
            S_DONE: begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_mem_rd     = r_mem_rd;
   assign o_mem_addr   = r_mem_addr;
   assign o_data_pipe1 = r_p1;
   assign o_data_pipe2 = r_p2;
   assign o_out_valid  = r_out_valid;
   assign o_sat_flag   = r_sat;
   assign o_busy       = r_busy;
   assign o_done       = r_done;

endmodule

// File: tb/tb_euler_dot_pipe.sv
// Bench for euler_dot_pipe: directed fixed-point cases plus random passes
// compared against a plain-arithmetic matrix/vector reference.
module tb_euler_dot_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_start;
   logic [15:0] i_n_dim, i_m_dim, i_a_base, i_b_base, i_x_base, i_u_base;
   logic        o_mem_rd;
   logic [15:0] o_mem_addr;
   logic [15:0] i_mem_data;
   logic [15:0] o_data_pipe1, o_data_pipe2;
   logic        o_out_valid;
   logic        i_out_ready;
   logic        o_sat_flag, o_busy, o_done;

   logic [15:0] mem [0:65535];
   int          checks = 0;
   int          errors = 0;
   int          rd_cnt = 0;
   int          rd_bad = 0;
   int          g_n, g_m, g_ab, g_bb, g_xb, g_ub;
   logic [15:0] exp_p1[$];
   logic [15:0] exp_p2[$];
   bit          exp_sat;

   euler_dot_pipe dut (
      .clk          (clk),
      .rst          (rst),
      .i_start      (i_start),
      .i_n_dim      (i_n_dim),
      .i_m_dim      (i_m_dim),
      .i_a_base     (i_a_base),
      .i_b_base     (i_b_base),
      .i_x_base     (i_x_base),
      .i_u_base     (i_u_base),
      .o_mem_rd     (o_mem_rd),
      .o_mem_addr   (o_mem_addr),
      .i_mem_data   (i_mem_data),
      .o_data_pipe1 (o_data_pipe1),
      .o_data_pipe2 (o_data_pipe2),
      .o_out_valid  (o_out_valid),
      .i_out_ready  (i_out_ready),
      .o_sat_flag   (o_sat_flag),
      .o_busy       (o_busy),
      .o_done       (o_done)
   );

   always #5 clk = ~clk;

   // RAM: one-cycle read latency; flag any read outside an active fetch
   always @(posedge clk) begin
      if (o_mem_rd) begin
         i_mem_data <= mem[o_mem_addr];
         rd_cnt     <= rd_cnt + 1;
         if (o_out_valid || !o_busy || rst) rd_bad <= rd_bad + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] clip16(input longint s);
      if (s > 32767)  begin exp_sat = 1'b1; return 16'h7FFF; end
      if (s < -32768) begin exp_sat = 1'b1; return 16'h8000; end
      return 16'(s);
   endfunction

   function automatic longint term(input logic [15:0] c, input logic [15:0] v);
      longint p;
      p = (longint'($signed(c)) * longint'($signed(v))) >>> 8;
      return longint'($signed(clip16(p)));
   endfunction

   // Reference: plain row-major matrix-vector products in Q8.8
   task automatic model();
      longint sa, sb;
      exp_p1.delete();
      exp_p2.delete();
      exp_sat = 1'b0;
      for (int i = 0; i < g_n; i++) begin
         sa = 0;
         sb = 0;
         for (int j = 0; j < g_n; j++) sa += term(mem[16'(g_ab + i*g_n + j)], mem[16'(g_xb + j)]);
         for (int k = 0; k < g_m; k++) sb += term(mem[16'(g_bb + i*g_m + k)], mem[16'(g_ub + k)]);
         exp_p1.push_back(clip16(sa));
         exp_p2.push_back(clip16(sb));
      end
   endtask

   task automatic setup(input int n, input int m, input int ab, input int bb, input int xb, input int ub);
      g_n = n; g_m = m; g_ab = ab; g_bb = bb; g_xb = xb; g_ub = ub;
   endtask

   task automatic load_s1();
      setup(2, 1, 'h100, 'h200, 'h300, 'h400);
      mem['h100] = 16'h0100; mem['h101] = 16'h0200;
      mem['h102] = 16'h0080; mem['h103] = 16'h0000;
      mem['h300] = 16'h0300; mem['h301] = 16'h0100;
      mem['h200] = 16'h0100; mem['h201] = 16'h0200;
      mem['h400] = 16'h0040;
      exp_p1 = '{16'h0500, 16'h0180};
      exp_p2 = '{16'h0040, 16'h0080};
      exp_sat = 1'b0;
   endtask

   task automatic pulse_start();
      i_n_dim = 16'(g_n); i_m_dim = 16'(g_m);
      i_a_base = 16'(g_ab); i_b_base = 16'(g_bb);
      i_x_base = 16'(g_xb); i_u_base = 16'(g_ub);
      @(negedge clk); i_start = 1'b1;
      @(negedge clk); i_start = 1'b0;
      // Inputs must have been captured at start; scramble them now
      i_n_dim = 16'($urandom); i_m_dim = 16'($urandom);
      i_a_base = 16'($urandom); i_b_base = 16'($urandom);
      i_x_base = 16'($urandom); i_u_base = 16'($urandom);
   endtask

   task automatic run_pass(input int stall0, input bit poke);
      int row, cyc, stalled, rd0, bad0;
      bit rdy, vseen;
      rd0 = rd_cnt; bad0 = rd_bad;
      pulse_start();
      chk("busy_after_start", 32'(o_busy), 1);
      row = 0; cyc = 0; stalled = 0; vseen = 0;
      while (row < g_n && cyc < 4000) begin
         i_start = (poke && cyc == 3);
         if (o_out_valid) begin
            chk("p1", 32'(o_data_pipe1), 32'(exp_p1[row]));
            chk("p2", 32'(o_data_pipe2), 32'(exp_p2[row]));
            rdy = (row == 0 && stalled < stall0) ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (row == 0 && !rdy) stalled++;
            i_out_ready = rdy;
            if (rdy) row++;
         end else begin
            i_out_ready = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      i_out_ready = 1'b0;
      i_start = 1'b0;
      chk("rows", 32'(row), 32'(g_n));
      cyc = 0;
      while (!o_done && cyc < 50) begin
         vseen |= o_out_valid;
         @(negedge clk);
         cyc++;
      end
      chk("done", 32'(o_done), 1);
      if (g_n == 0) begin
         chk("n0_done_latency", 32'(cyc), 1);
         chk("n0_valid", 32'(vseen), 0);
      end
      chk("sat_flag", 32'(o_sat_flag), 32'(exp_sat));
      @(negedge clk);
      chk("done_pulse", 32'(o_done), 0);
      chk("busy_end", 32'(o_busy), 0);
      chk("reads", 32'(rd_cnt - rd0), 32'(g_n * 2 * (g_n + g_m)));
      chk("bad_reads", 32'(rd_bad - bad0), 0);
   endtask

   function automatic logic [15:0] rnd16();
      if ($urandom_range(0, 3) == 0) return 16'($urandom);
      return 16'(int'($urandom_range(0, 2047)) - 1024);
   endfunction

   initial begin
      int n, m, cyc;
      for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
      rst = 1'b1; i_start = 1'b0; i_out_ready = 1'b0;
      i_n_dim = '0; i_m_dim = '0; i_a_base = '0; i_b_base = '0; i_x_base = '0; i_u_base = '0;
      repeat (3) @(negedge clk);
      chk("reset_outs", {13'd0, o_mem_rd, o_out_valid, o_busy, o_done, o_sat_flag,
                         o_data_pipe1 | o_data_pipe2}, 0);
      rst = 1'b0;
      @(negedge clk);

      // 1 basic, 2 stalled row0, 6 start while busy
      load_s1(); run_pass(0, 0);
      load_s1(); run_pass(5, 0);
      load_s1(); run_pass(0, 1);

      // 3 empty pass, then m=0
      setup(0, 3, 'h100, 'h200, 'h300, 'h400); model(); run_pass(0, 0);
      setup(1, 0, 'h700, 'h0, 'h710, 'h0);
      mem['h700] = 16'h0100; mem['h710] = 16'h0200;
      exp_p1 = '{16'h0200}; exp_p2 = '{16'h0000}; exp_sat = 1'b0;
      run_pass(0, 0);

      // 4 saturation, positive and negative
      setup(2, 0, 'h500, 'h0, 'h600, 'h0);
      mem['h500] = 16'h7F00; mem['h501] = 16'h7F00; mem['h502] = 16'h0; mem['h503] = 16'h0;
      mem['h600] = 16'h0100; mem['h601] = 16'h0100;
      exp_p1 = '{16'h7FFF, 16'h0000}; exp_p2 = '{16'h0000, 16'h0000}; exp_sat = 1'b1;
      run_pass(0, 0);
      mem['h500] = 16'h8100; mem['h501] = 16'h8100;
      exp_p1 = '{16'h8000, 16'h0000};
      run_pass(0, 0);

      // 5 reset in the middle of row1
      load_s1();
      pulse_start();
      i_out_ready = 1'b1;
      cyc = 0;
      while (!o_out_valid && cyc < 200) begin @(negedge clk); cyc++; end
      chk("rst_row0_valid", 32'(o_out_valid), 1);
      @(negedge clk);
      i_out_ready = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_outs", {13'd0, o_mem_rd, o_out_valid, o_busy, o_done, o_sat_flag,
                           o_data_pipe1 | o_data_pipe2}, 0);
      chk("rst_mid_addr", 32'(o_mem_addr), 0);
      rst = 1'b0;
      @(negedge clk);
      load_s1(); run_pass(0, 0);

      // Random passes against the reference
      for (int t = 0; t < 10; t++) begin
         n = $urandom_range(1, 4);
         m = $urandom_range(0, 3);
         setup(n, m, 'h1000 + $urandom_range(0, 255), 'h2000 + $urandom_range(0, 255),
               'h3000 + $urandom_range(0, 255), 'h4000 + $urandom_range(0, 255));
         for (int i = 0; i < n*n; i++) mem[16'(g_ab + i)] = rnd16();
         for (int i = 0; i < n*m; i++) mem[16'(g_bb + i)] = rnd16();
         for (int i = 0; i < n; i++)   mem[16'(g_xb + i)] = rnd16();
         for (int i = 0; i < m; i++)   mem[16'(g_ub + i)] = rnd16();
         model();
         run_pass($urandom_range(0, 3), $urandom_range(0, 1) == 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
